// File: rtl/am2940_sequencer_if.sv
// Pin-level bus between the sequencer and an AM2940 DMA address generator.
// The master side drives instruction/data/carries; the slave side returns data and done.
interface am2940_sequencer_if;
    logic [2:0] instruction;
    logic [7:0] data_out;
    logic       data_oe;
    logic [7:0] data_in;
    logic       oena;
    logic       cinac;
    logic       cinwc;
    logic       dma_done;

    modport master (
        output instruction, data_out, data_oe, oena, cinac, cinwc,
        input  data_in, dma_done
    );

    modport slave (
        input  instruction, data_out, data_oe, oena, cinac, cinwc,
        output data_in, dma_done
    );
endinterface

// File: rtl/am2940_sequencer.sv
// Programs an AM2940 (control, address, word count), steps it once per accepted
// memory beat until done/stop/timeout, then reads back both counters.
module am2940_sequencer #(
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 start,
    input  logic [1:0]           cfg_mode,
    input  logic                 cfg_dir,
    input  logic [7:0]           cfg_addr,
    input  logic [7:0]           cfg_count,
    input  logic                 stop,
    input  logic                 beat_ack,
    am2940_sequencer_if.master   bus,
    output logic                 beat_req,
    output logic                 busy,
    output logic                 finished,
    output logic                 aborted,
    output logic                 timeout_err,
    output logic [8:0]           beat_cnt,
    output logic [7:0]           final_addr,
    output logic [7:0]           final_wc
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_CR, S_WR_AR, S_WR_WC, S_RUN, S_RD_AC, S_RD_WC, S_FIN
    } state_t;

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(TIMEOUT);

    state_t            state_reg, state_next;
    logic [1:0]        mode_reg;
    logic              dir_reg;
    logic [7:0]        addr_reg;
    logic [7:0]        count_reg;
    logic [WAIT_W-1:0] wait_reg;
    logic [WAIT_W-1:0] wait_inc;
    logic              wait_hit;
    logic [8:0]        beat_cnt_reg;
    logic              aborted_reg;
    logic              timeout_reg;
    logic [7:0]        final_addr_reg;
    logic [7:0]        final_wc_reg;

    assign wait_inc = wait_reg + WAIT_W'(1);
    assign wait_hit = (TIMEOUT != 0) && !beat_ack && (wait_inc == TIMEOUT_V);

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Bus pins are decoded straight from state so reset forces NOP immediately.
    always_comb begin
        state_next      = state_reg;
        bus.instruction = 3'd7;
        bus.data_out    = 8'h00;
        bus.data_oe     = 1'b0;
        bus.oena        = 1'b1;
        bus.cinac       = 1'b1;
        bus.cinwc       = 1'b1;
        beat_req        = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) state_next = S_WR_CR;
            end
            S_WR_CR: begin
                bus.instruction = 3'd0;
                bus.data_oe     = 1'b1;
                bus.data_out    = {5'b0, dir_reg, mode_reg};
                state_next      = S_WR_AR;
            end
            S_WR_AR: begin
                bus.instruction = 3'd5;
                bus.data_oe     = 1'b1;
                bus.data_out    = addr_reg;
                state_next      = S_WR_WC;
            end
            S_WR_WC: begin
                bus.instruction = 3'd6;
                bus.data_oe     = 1'b1;
                bus.data_out    = count_reg;
                state_next      = S_RUN;
            end
            S_RUN: begin
                bus.oena  = 1'b0;
                beat_req  = 1'b1;
                bus.cinac = ~beat_ack;
                bus.cinwc = ~beat_ack;
                if (stop || (beat_ack && bus.dma_done) || wait_hit) begin
                    state_next = S_RD_AC;
                end
            end
            S_RD_AC: begin
                bus.instruction = 3'd3;
                state_next      = S_RD_WC;
            end
            S_RD_WC: begin
                bus.instruction = 3'd2;
                state_next      = S_FIN;
            end
            S_FIN: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            mode_reg       <= 2'd0;
            dir_reg        <= 1'b0;
            addr_reg       <= 8'h00;
            count_reg      <= 8'h00;
            wait_reg       <= '0;
            beat_cnt_reg   <= 9'd0;
            aborted_reg    <= 1'b0;
            timeout_reg    <= 1'b0;
            final_addr_reg <= 8'h00;
            final_wc_reg   <= 8'h00;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        mode_reg     <= cfg_mode;
                        dir_reg      <= cfg_dir;
                        addr_reg     <= cfg_addr;
                        count_reg    <= cfg_count;
                        wait_reg     <= '0;
                        beat_cnt_reg <= 9'd0;
                        aborted_reg  <= 1'b0;
                        timeout_reg  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (beat_ack) begin
                        wait_reg <= '0;
                        if (beat_cnt_reg != 9'h1FF) beat_cnt_reg <= beat_cnt_reg + 9'd1;
                    end else if (TIMEOUT != 0) begin
                        wait_reg <= wait_inc;
                    end
                    // A stop outranks a coincident timeout or last beat.
                    if (stop) aborted_reg <= 1'b1;
                    else if (wait_hit) timeout_reg <= 1'b1;
                end
                S_RD_AC: final_addr_reg <= bus.data_in;
                S_RD_WC: final_wc_reg   <= bus.data_in;
                default: ;
            endcase
        end
    end

    assign busy        = (state_reg != S_IDLE);
    assign finished    = (state_reg == S_FIN);
    assign aborted     = aborted_reg;
    assign timeout_err = timeout_reg;
    assign beat_cnt    = beat_cnt_reg;
    assign final_addr  = final_addr_reg;
    assign final_wc    = final_wc_reg;

endmodule

// File: tb/tb_am2940_sequencer.sv
// Directed bench for am2940_sequencer with a small behavioural AM2940 on the bus.
module tb_am2940_sequencer;

    logic       clk = 1'b0;
    logic       res = 1'b0;
    logic       start = 1'b0;
    logic [1:0] cfg_mode = 2'd0;
    logic       cfg_dir = 1'b0;
    logic [7:0] cfg_addr = 8'h00;
    logic [7:0] cfg_count = 8'h00;
    logic       stop = 1'b0;
    logic       beat_ack = 1'b0;
    logic       beat_req, busy, finished, aborted, timeout_err;
    logic [8:0] beat_cnt;
    logic [7:0] final_addr, final_wc;

    int checks = 0;
    int errors = 0;

    am2940_sequencer_if bus ();

    am2940_sequencer #(.TIMEOUT(4)) dut (
        .clk(clk), .res(res), .start(start),
        .cfg_mode(cfg_mode), .cfg_dir(cfg_dir), .cfg_addr(cfg_addr), .cfg_count(cfg_count),
        .stop(stop), .beat_ack(beat_ack), .bus(bus),
        .beat_req(beat_req), .busy(busy), .finished(finished), .aborted(aborted),
        .timeout_err(timeout_err), .beat_cnt(beat_cnt),
        .final_addr(final_addr), .final_wc(final_wc)
    );

    always #5 clk = ~clk;

    // Behavioural AM2940: mode 0 counts WC down (done at 1), mode 1 counts WC up
    // from 0 (done at count-1), mode 2 compares address with WC, mode 3 never done.
    logic [2:0] m_cr = 3'd0;
    logic [7:0] m_ac = 8'h00, m_wc = 8'h00, m_wcr = 8'h00;

    always @(posedge clk) begin
        if (bus.data_oe) begin
            case (bus.instruction)
                3'd0: m_cr <= bus.data_out[2:0];
                3'd5: m_ac <= bus.data_out;
                3'd6: begin
                    m_wcr <= bus.data_out;
                    m_wc  <= (m_cr[1:0] == 2'd1) ? 8'h00 : bus.data_out;
                end
                default: ;
            endcase
        end else if (bus.instruction == 3'd7) begin
            if (!bus.cinac) m_ac <= m_cr[2] ? m_ac - 8'd1 : m_ac + 8'd1;
            if (!bus.cinwc) begin
                if (m_cr[1:0] == 2'd0) m_wc <= m_wc - 8'd1;
                else if (m_cr[1:0] == 2'd1) m_wc <= m_wc + 8'd1;
            end
        end
    end

    assign bus.dma_done = (m_cr[1:0] == 2'd0) ? (m_wc == 8'd1) :
                          (m_cr[1:0] == 2'd1) ? (m_wc == m_wcr - 8'd1) :
                          (m_cr[1:0] == 2'd2) ? (m_ac == m_wc) : 1'b0;
    assign bus.data_in  = (bus.instruction == 3'd3) ? m_ac :
                          (bus.instruction == 3'd2) ? m_wc : 8'h00;

    // Runs one transaction; ack_gap<0 means never ack, stop_after>0 raises stop
    // (without ack) once that many beats have been acked.
    task automatic run_txn(input logic [1:0] mode, input logic dir, input logic [7:0] addr,
                           input logic [7:0] count, input int ack_gap, input int stop_after,
                           input bit poke_start, output int lat_req, output int run_cycles,
                           output int acks, output int lat_fin, output bit fin_gone);
        bit ack_now, stop_now;
        cfg_mode = mode; cfg_dir = dir; cfg_addr = addr; cfg_count = count;
        start = 1'b1;
        lat_req = 0;
        do begin
            @(posedge clk); #1;
            start = 1'b0;
            lat_req++;
        end while (!beat_req && lat_req < 20);
        run_cycles = 0; acks = 0;
        while (beat_req && run_cycles < 200) begin
            ack_now  = (ack_gap >= 0) && ((run_cycles % (ack_gap + 1)) == ack_gap);
            stop_now = (stop_after > 0) && (acks == stop_after);
            if (stop_now) ack_now = 1'b0;
            beat_ack = ack_now; stop = stop_now; start = poke_start;
            @(posedge clk); #1;
            if (ack_now) acks++;
            run_cycles++;
            beat_ack = 1'b0; stop = 1'b0; start = 1'b0;
        end
        lat_fin = 1;
        while (!finished && lat_fin < 10) begin
            @(posedge clk); #1;
            lat_fin++;
        end
        @(posedge clk); #1;
        fin_gone = !finished && !busy;
        $display("TXN mode=%0d dir=%0d addr=%02h count=%02h acks=%0d run=%0d lat_req=%0d lat_fin=%0d beat_cnt=%0d fa=%02h fwc=%02h ab=%0d to=%0d",
                 mode, dir, addr, count, acks, run_cycles, lat_req, lat_fin, beat_cnt,
                 final_addr, final_wc, aborted, timeout_err);
    endtask

    task automatic test_reset();
        #2;
        checks++; if (bus.instruction !== 3'd7 || bus.data_oe !== 1'b0 || bus.data_out !== 8'h00) begin
            errors++; $display("FAIL reset_bus instr=%0d oe=%0d data=%02h want 7 0 00", bus.instruction, bus.data_oe, bus.data_out); end
        checks++; if (bus.oena !== 1'b1 || bus.cinac !== 1'b1 || bus.cinwc !== 1'b1) begin
            errors++; $display("FAIL reset_pins oena=%0d cinac=%0d cinwc=%0d want 1 1 1", bus.oena, bus.cinac, bus.cinwc); end
        checks++; if ({beat_req, busy, finished, aborted, timeout_err} !== 5'b0 || beat_cnt !== 9'd0 ||
                      final_addr !== 8'h00 || final_wc !== 8'h00) begin
            errors++; $display("FAIL reset_status req/busy/fin/ab/to=%05b cnt=%0d fa=%02h fwc=%02h want all 0",
                               {beat_req, busy, finished, aborted, timeout_err}, beat_cnt, final_addr, final_wc); end
        @(negedge clk); res = 1'b1;
        $display("TXN reset released");
    endtask

    task automatic test_program_cycle();
        @(posedge clk); #1;
        cfg_mode = 2'd2; cfg_dir = 1'b1; cfg_addr = 8'hA5; cfg_count = 8'h3C; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        checks++; if (bus.instruction !== 3'd0 || bus.data_oe !== 1'b1 || bus.data_out !== 8'h06 || busy !== 1'b1) begin
            errors++; $display("FAIL wr_cr instr=%0d oe=%0d data=%02h busy=%0d want 0 1 06 1", bus.instruction, bus.data_oe, bus.data_out, busy); end
        @(posedge clk); #1;
        checks++; if (bus.instruction !== 3'd5 || bus.data_out !== 8'hA5) begin
            errors++; $display("FAIL wr_ar instr=%0d data=%02h want 5 a5", bus.instruction, bus.data_out); end
        @(posedge clk); #1;
        checks++; if (bus.instruction !== 3'd6 || bus.data_out !== 8'h3C) begin
            errors++; $display("FAIL wr_wc instr=%0d data=%02h want 6 3c", bus.instruction, bus.data_out); end
        @(posedge clk); #1;
        checks++; if (bus.instruction !== 3'd7 || bus.oena !== 1'b0 || beat_req !== 1'b1 || bus.cinac !== 1'b1 || bus.data_oe !== 1'b0) begin
            errors++; $display("FAIL run_idle instr=%0d oena=%0d req=%0d cinac=%0d oe=%0d want 7 0 1 1 0",
                               bus.instruction, bus.oena, beat_req, bus.cinac, bus.data_oe); end
        beat_ack = 1'b1; stop = 1'b1; #1;
        checks++; if (bus.cinac !== 1'b0 || bus.cinwc !== 1'b0) begin
            errors++; $display("FAIL run_ack_carry cinac=%0d cinwc=%0d want 0 0", bus.cinac, bus.cinwc); end
        @(posedge clk); #1; beat_ack = 1'b0; stop = 1'b0;
        checks++; if (bus.instruction !== 3'd3 || bus.data_oe !== 1'b0 || beat_req !== 1'b0) begin
            errors++; $display("FAIL rd_ac instr=%0d oe=%0d req=%0d want 3 0 0", bus.instruction, bus.data_oe, beat_req); end
        @(posedge clk); #1;
        checks++; if (bus.instruction !== 3'd2 || final_addr !== 8'hA4) begin
            errors++; $display("FAIL rd_wc instr=%0d fa=%02h want 2 a4", bus.instruction, final_addr); end
        @(posedge clk); #1;
        checks++; if (finished !== 1'b1 || busy !== 1'b1 || final_wc !== 8'h3C || beat_cnt !== 9'd1 || aborted !== 1'b1) begin
            errors++; $display("FAIL fin_stop_ack fin=%0d busy=%0d fwc=%02h cnt=%0d ab=%0d want 1 1 3c 1 1",
                               finished, busy, final_wc, beat_cnt, aborted); end
        @(posedge clk); #1;
        $display("TXN program cycle mode=2 dir=1 addr=a5 count=3c stop+ack");
    endtask

    task automatic test_mode0_inc();
        int lr, rc, ac, lf; bit fg;
        run_txn(2'd0, 1'b0, 8'h10, 8'd3, 0, 0, 1'b0, lr, rc, ac, lf, fg);
        checks++; if (lr !== 4 || lf !== 3) begin
            errors++; $display("FAIL m0_latency start->req=%0d ack->fin=%0d want 4 3", lr, lf); end
        checks++; if (ac !== 3 || rc !== 3 || beat_cnt !== 9'd3) begin
            errors++; $display("FAIL m0_beats acks=%0d run=%0d cnt=%0d want 3 3 3", ac, rc, beat_cnt); end
        checks++; if (final_addr !== 8'h13 || final_wc !== 8'h00 || aborted !== 1'b0 || timeout_err !== 1'b0 || !fg) begin
            errors++; $display("FAIL m0_result fa=%02h fwc=%02h ab=%0d to=%0d idle=%0d want 13 00 0 0 1",
                               final_addr, final_wc, aborted, timeout_err, fg); end
    endtask

    task automatic test_mode1_gapped();
        int lr, rc, ac, lf; bit fg;
        run_txn(2'd1, 1'b0, 8'h40, 8'd2, 1, 0, 1'b0, lr, rc, ac, lf, fg);
        checks++; if (ac !== 2 || rc !== 4 || beat_cnt !== 9'd2) begin
            errors++; $display("FAIL m1_beats acks=%0d run=%0d cnt=%0d want 2 4 2", ac, rc, beat_cnt); end
        checks++; if (final_addr !== 8'h42 || final_wc !== 8'h02 || lf !== 3) begin
            errors++; $display("FAIL m1_result fa=%02h fwc=%02h lat_fin=%0d want 42 02 3", final_addr, final_wc, lf); end
    endtask

    task automatic test_mode2_dec();
        int lr, rc, ac, lf; bit fg;
        run_txn(2'd2, 1'b1, 8'h20, 8'h1D, 0, 0, 1'b0, lr, rc, ac, lf, fg);
        checks++; if (ac !== 4 || beat_cnt !== 9'd4) begin
            errors++; $display("FAIL m2_beats acks=%0d cnt=%0d want 4 4", ac, beat_cnt); end
        checks++; if (final_addr !== 8'h1C || final_wc !== 8'h1D) begin
            errors++; $display("FAIL m2_result fa=%02h fwc=%02h want 1c 1d", final_addr, final_wc); end
    endtask

    task automatic test_mode3_stop();
        int lr, rc, ac, lf; bit fg;
        run_txn(2'd3, 1'b0, 8'h80, 8'h09, 0, 5, 1'b1, lr, rc, ac, lf, fg);
        checks++; if (aborted !== 1'b1 || timeout_err !== 1'b0 || beat_cnt !== 9'd5 || rc !== 6) begin
            errors++; $display("FAIL m3_stop ab=%0d to=%0d cnt=%0d run=%0d want 1 0 5 6", aborted, timeout_err, beat_cnt, rc); end
        checks++; if (final_addr !== 8'h85 || !fg) begin
            errors++; $display("FAIL m3_result fa=%02h idle=%0d want 85 1", final_addr, fg); end
    endtask

    task automatic test_timeout();
        int lr, rc, ac, lf; bit fg;
        run_txn(2'd0, 1'b0, 8'h55, 8'h07, -1, 0, 1'b0, lr, rc, ac, lf, fg);
        checks++; if (timeout_err !== 1'b1 || aborted !== 1'b0 || rc !== 4 || beat_cnt !== 9'd0) begin
            errors++; $display("FAIL timeout to=%0d ab=%0d run=%0d cnt=%0d want 1 0 4 0", timeout_err, aborted, rc, beat_cnt); end
        checks++; if (final_addr !== 8'h55 || final_wc !== 8'h07 || lf !== 3) begin
            errors++; $display("FAIL timeout_readback fa=%02h fwc=%02h lat_fin=%0d want 55 07 3", final_addr, final_wc, lf); end
    endtask

    task automatic test_reset_mid_run();
        int lr, rc, ac, lf; bit fg;
        cfg_mode = 2'd0; cfg_dir = 1'b0; cfg_addr = 8'h30; cfg_count = 8'd9; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        beat_ack = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        beat_ack = 1'b0; #2;
        res = 1'b0; #1;
        checks++; if (busy !== 1'b0 || beat_req !== 1'b0 || bus.instruction !== 3'd7 || bus.oena !== 1'b1 ||
                      beat_cnt !== 9'd0 || final_addr !== 8'h00 || final_wc !== 8'h00 || timeout_err !== 1'b0) begin
            errors++; $display("FAIL midrun_reset busy=%0d req=%0d instr=%0d oena=%0d cnt=%0d fa=%02h fwc=%02h to=%0d want 0 0 7 1 0 00 00 0",
                               busy, beat_req, bus.instruction, bus.oena, beat_cnt, final_addr, final_wc, timeout_err); end
        @(negedge clk); res = 1'b1;
        @(posedge clk); #1;
        run_txn(2'd0, 1'b0, 8'h30, 8'd2, 0, 0, 1'b0, lr, rc, ac, lf, fg);
        checks++; if (beat_cnt !== 9'd2 || final_addr !== 8'h32 || final_wc !== 8'h00 || lr !== 4) begin
            errors++; $display("FAIL after_reset cnt=%0d fa=%02h fwc=%02h lat_req=%0d want 2 32 00 4", beat_cnt, final_addr, final_wc, lr); end
    endtask

    initial begin
        test_reset();
        test_program_cycle();
        test_mode0_inc();
        test_mode1_gapped();
        test_mode2_dec();
        test_mode3_stop();
        test_timeout();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
